// File: rtl/store_mem_arbiter.sv
// Arbitrates the single data-memory write port among STORER_NUM store reservation stations.
// Define STORE_ARB_RR_EN for round-robin grants; otherwise the lowest eligible index wins.
module store_mem_arbiter #(
  parameter int STORER_NUM = 2,
  parameter int WORD_SIZE  = 32,
  parameter int RB_INDEX   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [STORER_NUM-1:0]            req,
  input  logic [STORER_NUM*WORD_SIZE-1:0]  addr_bus,
  input  logic [STORER_NUM*WORD_SIZE-1:0]  data_bus,
  input  logic [STORER_NUM*RB_INDEX-1:0]   rb_index_bus,
  output logic                             mem_we,
  output logic [WORD_SIZE-1:0]             mem_addr,
  output logic [WORD_SIZE-1:0]             mem_wdata,
  input  logic                             mem_ack,
  output logic [STORER_NUM-1:0]            release_bus,
  output logic                             commit_valid,
  output logic [RB_INDEX-1:0]              commit_rb_index,
  output logic                             busy
);

  localparam int IDX_W = $clog2(STORER_NUM);

  typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

  state_t                  state;
  logic [STORER_NUM-1:0]   cooldown;
  logic [STORER_NUM-1:0]   eligible;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_found;
  logic [IDX_W-1:0]        grant_q;
  logic [RB_INDEX-1:0]     rb_q;
  logic [STORER_NUM-1:0]   grant_mask;

  logic [WORD_SIZE-1:0]    addr_arr [STORER_NUM];
  logic [WORD_SIZE-1:0]    data_arr [STORER_NUM];
  logic [RB_INDEX-1:0]     rb_arr   [STORER_NUM];

  for (genvar i = 0; i < STORER_NUM; i++) begin : g_unpack
    assign addr_arr[i] = addr_bus[i*WORD_SIZE +: WORD_SIZE];
    assign data_arr[i] = data_bus[i*WORD_SIZE +: WORD_SIZE];
    assign rb_arr[i]   = rb_index_bus[i*RB_INDEX +: RB_INDEX];
  end

  // A storer just released still shows req for one cycle; cooldown hides it.
  assign eligible   = req & ~cooldown;
  assign grant_mask = {{(STORER_NUM-1){1'b0}}, 1'b1} << grant_q;

`ifdef STORE_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  int               cand;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < STORER_NUM; k++) begin
      cand = (int'(rr_ptr) + k) % STORER_NUM;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end
`else
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = STORER_NUM - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cooldown        <= '0;
      grant_q         <= '0;
      rb_q            <= '0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      release_bus     <= '0;
      commit_valid    <= 1'b0;
      commit_rb_index <= '0;
      busy            <= 1'b0;
`ifdef STORE_ARB_RR_EN
      rr_ptr          <= '0;
`endif
    end else begin
      release_bus  <= '0;
      commit_valid <= 1'b0;
      case (state)
        IDLE: begin
          cooldown <= '0;
          if (grant_found) begin
            grant_q   <= grant_idx;
            mem_addr  <= addr_arr[grant_idx];
            mem_wdata <= data_arr[grant_idx];
            rb_q      <= rb_arr[grant_idx];
            mem_we    <= 1'b1;
            busy      <= 1'b1;
            state     <= WRITE;
`ifdef STORE_ARB_RR_EN
            rr_ptr    <= (grant_idx == IDX_W'(STORER_NUM - 1)) ? '0 : grant_idx + IDX_W'(1);
`endif
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_we          <= 1'b0;
            release_bus     <= grant_mask;
            commit_valid    <= 1'b1;
            commit_rb_index <= rb_q;
            state           <= RELEASE;
          end
        end
        RELEASE: begin
          busy     <= 1'b0;
          cooldown <= grant_mask;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_mem_arbiter.sv
// Self-checking bench for store_mem_arbiter with three storers: table-driven single-storer
// sequence plus hand-written grant-order, throughput and reset-abort sequences.
module tb_store_mem_arbiter;

  localparam int N = 3;
  localparam int W = 32;
  localparam int R = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   addr_bus;
  logic [N*W-1:0]   data_bus;
  logic [N*R-1:0]   rb_index_bus;
  logic             mem_we;
  logic [W-1:0]     mem_addr;
  logic [W-1:0]     mem_wdata;
  logic             mem_ack;
  logic [N-1:0]     release_bus;
  logic             commit_valid;
  logic [R-1:0]     commit_rb_index;
  logic             busy;

  int checks = 0;
  int errors = 0;

  store_mem_arbiter #(.STORER_NUM(N), .WORD_SIZE(W), .RB_INDEX(R)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .addr_bus        (addr_bus),
    .data_bus        (data_bus),
    .rb_index_bus    (rb_index_bus),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .release_bus     (release_bus),
    .commit_valid    (commit_valid),
    .commit_rb_index (commit_rb_index),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] a0;
    logic [W-1:0] d0;
    logic         ack;
    logic         we;
    logic [W-1:0] ea;
    logic [W-1:0] ed;
    logic [N-1:0] rel;
    logic         cv;
    logic [R-1:0] erb;
    logic         busy;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_storer(input int i, input logic [W-1:0] a, input logic [W-1:0] d,
                            input logic [R-1:0] rb);
    addr_bus[i*W +: W]     = a;
    data_bus[i*W +: W]     = d;
    rb_index_bus[i*R +: R] = rb;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"}, mem_we, 1'b0);
    check({tag, "_rel"}, release_bus, '0);
    check({tag, "_cv"}, commit_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    req     = '0;
    mem_ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_quiet("rst");
    step();
    reset = 1'b0;
  endtask

  // Runs with req held and ack tied high, recording the order and spacing of release pulses.
  task automatic run_stream(input string tag, input logic [N-1:0] r, input int exp_order[4],
                            input int exp_gap);
    int k = 0;
    int last = 0;
    int idx;
    logic [W-1:0] seen_addr = '0;
    req     = r;
    mem_ack = 1'b1;
    for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
      step();
      if (mem_we) seen_addr = mem_addr;
      if (release_bus != '0 || commit_valid) begin
        idx = 0;
        for (int j = 0; j < N; j++) if (release_bus[j]) idx = j;
        check({tag, "_onehot"}, $onehot(release_bus), 1'b1);
        check({tag, "_cv"}, commit_valid, 1'b1);
        check({tag, "_we_low"}, mem_we, 1'b0);
        check({tag, "_grant"}, idx, exp_order[k]);
        check({tag, "_rb"}, commit_rb_index, R'(5 + idx));
        check({tag, "_addr"}, seen_addr, W'(32'h100 + idx));
        if (k > 0) check({tag, "_gap"}, cyc - last, exp_gap);
        last = cyc;
        k++;
      end
    end
    check({tag, "_commits"}, k, 4);
    req     = '0;
    mem_ack = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order_rr[4];
    int order_fp[4];
    int order_one[4];
    order_rr  = '{0, 1, 2, 0};
    order_fp  = '{0, 1, 0, 1};
    order_one = '{0, 0, 0, 0};

    //          req     a0     d0     ack   we    ea     ed     rel     cv    erb   busy
    vecs[0] = '{3'b001, 32'h10, 32'hAB, 1'b0, 1'b1, 32'h10, 32'hAB, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[1] = '{3'b001, 32'h55, 32'hCD, 1'b0, 1'b1, 32'h10, 32'hAB, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[2] = '{3'b001, 32'h55, 32'hCD, 1'b0, 1'b1, 32'h10, 32'hAB, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[3] = '{3'b001, 32'h55, 32'hCD, 1'b1, 1'b0, 32'h0,  32'h0,  3'b001, 1'b1, 4'd3, 1'b1};
    vecs[4] = '{3'b001, 32'h55, 32'hCD, 1'b1, 1'b0, 32'h0,  32'h0,  3'b000, 1'b0, 4'd0, 1'b0};
    vecs[5] = '{3'b001, 32'h55, 32'hCD, 1'b1, 1'b0, 32'h0,  32'h0,  3'b000, 1'b0, 4'd0, 1'b0};
    vecs[6] = '{3'b001, 32'h55, 32'hCD, 1'b0, 1'b1, 32'h55, 32'hCD, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[7] = '{3'b000, 32'h55, 32'hCD, 1'b1, 1'b0, 32'h0,  32'h0,  3'b001, 1'b1, 4'd3, 1'b1};
    vecs[8] = '{3'b000, 32'h55, 32'hCD, 1'b0, 1'b0, 32'h0,  32'h0,  3'b000, 1'b0, 4'd0, 1'b0};

    reset        = 1'b0;
    req          = '0;
    mem_ack      = 1'b0;
    addr_bus     = '0;
    data_bus     = '0;
    rb_index_bus = '0;
    for (int i = 0; i < N; i++) set_storer(i, W'(32'h100 + i), W'(32'h200 + i), R'(5 + i));
    do_reset();
    check_quiet("post_rst");

    // Single storer: write held through slow ack, input changes ignored, cooldown cycle.
    set_storer(0, 32'h10, 32'hAB, 4'd3);
    for (int i = 0; i < 9; i++) begin
      req     = vecs[i].req;
      addr_bus[0 +: W] = vecs[i].a0;
      data_bus[0 +: W] = vecs[i].d0;
      mem_ack = vecs[i].ack;
      step();
      check($sformatf("v%0d_we", i), mem_we, vecs[i].we);
      check($sformatf("v%0d_rel", i), release_bus, vecs[i].rel);
      check($sformatf("v%0d_cv", i), commit_valid, vecs[i].cv);
      check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      if (vecs[i].we) begin
        check($sformatf("v%0d_addr", i), mem_addr, vecs[i].ea);
        check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].ed);
      end
      if (vecs[i].cv) check($sformatf("v%0d_rb", i), commit_rb_index, vecs[i].erb);
    end

    // All three storers requesting, ack tied high.
    for (int i = 0; i < N; i++) set_storer(i, W'(32'h100 + i), W'(32'h200 + i), R'(5 + i));
    do_reset();
`ifdef STORE_ARB_RR_EN
    run_stream("order", 3'b111, order_rr, 3);
`else
    run_stream("order", 3'b111, order_fp, 3);
`endif

    // One storer held continuously: a commit every 4 cycles.
    do_reset();
    run_stream("tput", 3'b001, order_one, 4);

    // Reset while storer 1 is mid-write: no pulse, then re-granted after reset.
    do_reset();
    set_storer(1, 32'h200, 32'h300, 4'd9);
    req = 3'b010;
    step();
    check("abort_we", mem_we, 1'b1);
    check("abort_addr", mem_addr, 32'h200);
    step();
    #2;
    reset = 1'b1;
    #1;
    check_quiet("abort_rst");
    step();
    check_quiet("abort_hold");
    reset = 1'b0;
    step();
    check("regrant_we", mem_we, 1'b1);
    check("regrant_addr", mem_addr, 32'h200);
    check("regrant_wdata", mem_wdata, 32'h300);
    check("regrant_rel", release_bus, 3'b000);
    mem_ack = 1'b1;
    step();
    check("regrant_relpulse", release_bus, 3'b010);
    check("regrant_cv", commit_valid, 1'b1);
    check("regrant_rb", commit_rb_index, 4'd9);
    req     = '0;
    mem_ack = 1'b0;
    step();
    check_quiet("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
